game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Central game sequencer for the 1A2B (bulls-and-cows) board game; sits directly upstream of the display controller and drives all of its inputs.
- Conditions the raw push-buttons and switches, then runs the main FSM.
- Latches the secret target and each guess digit-by-digit, validates switch candidates, counts remaining chances and generates the blink phase.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable-low cycles before a key press is accepted (10 ms at 50 MHz).
- BLINK_HALF, 12500000, cycles per blink half-period.
- MAX_CHANCES, 5, guesses per game; legal range 1..7.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- key_confirm_n  in  1  raw confirm button, active-low, asynchronous.
- key_restart_n  in  1  raw restart button, active-low, asynchronous.
- sw  in  4  raw switch value, asynchronous.
- state  out  state_t  current FSM state (game_types enum).
- blink_on  out  1  blink phase, 1 = visible.
- target  out  4x4 unpacked [3:0]  secret digits; [3] is leftmost.
- guess  out  4x4 unpacked [3:0]  current guess digits.
- candidate  out  4  synchronized switch value.
- sw_valid  out  1  candidate is legal for the current entry state.
- chances  out  3  remaining guesses.

Behaviour:
- Reset (async assert, sync release) values:
  - state = S_IDLE, chances = MAX_CHANCES.
  - target and guess all 0, blink_on = 1, counters 0.
  - Sync flops reset to 1 for keys and 0 for sw.
- Input conditioning:
  - Each key and sw passes through a 2-FF synchronizer.
  - Key debounce: a counter increments while the synced key is low and clears to 0 when it is high.
  - A single-cycle press pulse fires in the cycle the counter reaches DEBOUNCE_CYCLES; the counter then saturates.
  - One pulse per press; holding the key gives no repeat.
  - Latency from raw key low to pulse is 2 + DEBOUNCE_CYCLES cycles.
- candidate = synced sw, purely combinational from the sync flops.
- sw_valid:
  - Asserted only in S_SET_Dn or S_GUESS_Dn, and only if candidate <= 9 and candidate differs from every digit already committed in this entry phase.
  - Committed digits are indices 3 down to n+1 of target (set phase) or of guess (guess phase).
  - 0 in all other states.
- FSM, confirm-pulse driven; every transition takes effect on the clock edge after the pulse cycle:
  - S_IDLE -> S_SET_D3.
  - S_SET_Dn with sw_valid: target[n] <= candidate, then D3 -> D2 -> D1 -> D0.
  - S_SET_D0 with sw_valid: target[0] <= candidate, guess cleared to 0, next state S_GUESS_D3.
  - S_GUESS_Dn with sw_valid: guess[n] <= candidate, same D3..D0 progression.
  - S_GUESS_D0 with sw_valid: guess[0] <= candidate, chances <= chances-1 (saturating at 0), next state S_SHOW_RESULT.
  - S_SHOW_RESULT: if guess == target (all four digits) -> S_WIN; else if chances == 0 -> S_LOSE; else guess cleared and -> S_GUESS_D3.
  - S_WIN or S_LOSE -> S_IDLE, with chances = MAX_CHANCES and target/guess cleared.
  - Confirm while sw_valid = 0 in an entry state is ignored: no state, digit or chance change.
- Restart pulse from any state:
  - Next state S_IDLE, chances = MAX_CHANCES, target and guess cleared.
  - Restart has priority over a confirm pulse in the same cycle.
- Blink:
  - Counter counts 0..BLINK_HALF-1; at wrap it returns to 0 and toggles blink_on.
  - On any state change the counter resets to 0 and blink_on is forced to 1, so a newly active digit is visible immediately.
- Unreachable or illegal state encodings recover to S_IDLE on the next edge.
- Reset asserted mid-game: immediate return to reset values, no partial digit commit.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_HALF=8.
1. Normal entry:
   - Stimulus: reset, confirm from IDLE, set target 1,2,3,4.
   - Required: state S_GUESS_D3, target = {1,2,3,4}, chances = 5.
   - Stimulus: guess 1,2,3,4.
   - Required: S_SHOW_RESULT with chances = 4; next confirm -> S_WIN; next confirm -> S_IDLE with chances = 5.
2. Validation:
   - In S_SET_D2 with target[3] = 7: sw = 7 -> sw_valid = 0 and confirm ignored.
   - sw = 10 -> sw_valid = 0.
   - sw = 9 -> sw_valid = 1; confirm commits target[2] = 9.
3. Lose path:
   - Stimulus: target 1,2,3,4; five wrong guesses of 5,6,7,8.
   - Required: chances 4,3,2,1,0 after each guess; final result confirm -> S_LOSE.
   - A further guess is never entered, so chances never underflow.
4. Debounce:
   - Key low for 3 cycles then high -> no transition.
   - Key low for 20 cycles -> exactly one transition, occurring 2+4 cycles after the falling edge.
   - Key bouncing 1-cycle glitches -> no transition.
5. Blink:
   - Idle state: blink_on toggles every 8 cycles.
   - Confirm mid-period -> blink_on = 1 and counter = 0 on the state change.
6. Restart priority and async reset:
   - Restart and confirm pulses in the same cycle in S_GUESS_D1 -> S_IDLE, chances = 5, target = guess = 0.
   - rst_n pulsed low between clock edges -> outputs take reset values immediately.

Source files
------------

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - 1A2B game sequencer: input conditioning, main FSM, digit latches, chance counter, blink phase
//
// Ports:
//   clk, rst_n                    system clock, asynchronous active-low reset
//   key_confirm_n, key_restart_n  raw active-low push-buttons
//   sw[3:0]                       raw switch value
//   state                         current FSM state (game_types::state_t)
//   blink_on                      blink phase, 1 = visible
//   target[3:0], guess[3:0]       secret and guess digits, [3] is leftmost
//   candidate                     synchronized switch value
//   sw_valid                      candidate may be committed in the current entry state
//   chances                       remaining guesses

package game_types;
    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SET_D3      = 4'd1,
        S_SET_D2      = 4'd2,
        S_SET_D1      = 4'd3,
        S_SET_D0      = 4'd4,
        S_GUESS_D3    = 4'd5,
        S_GUESS_D2    = 4'd6,
        S_GUESS_D1    = 4'd7,
        S_GUESS_D0    = 4'd8,
        S_SHOW_RESULT = 4'd9,
        S_WIN         = 4'd10,
        S_LOSE        = 4'd11
    } state_t;
endpackage

// 2-FF synchronizer plus saturating debounce counter; one press pulse per held press.
module game_ctrl_key #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int DW = $clog2(CYCLES + 1);

    logic          s1, s2;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2) begin
                cnt <= '0;
            end else if (cnt != DW'(CYCLES)) begin
                cnt   <= cnt + 1'b1;
                // pulse is high exactly in the cycle the counter sits at CYCLES for the first time
                press <= (cnt == DW'(CYCLES - 1));
            end
        end
    end
endmodule

module game_ctrl
    import game_types::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 12500000,
    parameter int MAX_CHANCES     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_confirm_n,
    input  logic       key_restart_n,
    input  logic [3:0] sw,
    output state_t     state,
    output logic       blink_on,
    output logic [3:0] target [3:0],
    output logic [3:0] guess [3:0],
    output logic [3:0] candidate,
    output logic       sw_valid,
    output logic [2:0] chances
);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic          confirm, restart;
    logic [3:0]    sw_s1, sw_s2;
    logic [BW-1:0] blink_cnt;
    state_t        state_nx;
    logic          entry, entry_set, dup, match;
    logic [1:0]    entry_idx;

    game_ctrl_key #(.CYCLES(DEBOUNCE_CYCLES)) u_key_confirm (
        .clk(clk), .rst_n(rst_n), .key_n(key_confirm_n), .press(confirm)
    );
    game_ctrl_key #(.CYCLES(DEBOUNCE_CYCLES)) u_key_restart (
        .clk(clk), .rst_n(rst_n), .key_n(key_restart_n), .press(restart)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= 4'd0;
            sw_s2 <= 4'd0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    assign candidate = sw_s2;

    // Which digit is being entered, and whether it belongs to the target or the guess.
    always_comb begin
        entry     = 1'b1;
        entry_set = 1'b0;
        entry_idx = 2'd0;
        case (state)
            S_SET_D3:   begin entry_set = 1'b1; entry_idx = 2'd3; end
            S_SET_D2:   begin entry_set = 1'b1; entry_idx = 2'd2; end
            S_SET_D1:   begin entry_set = 1'b1; entry_idx = 2'd1; end
            S_SET_D0:   begin entry_set = 1'b1; entry_idx = 2'd0; end
            S_GUESS_D3: entry_idx = 2'd3;
            S_GUESS_D2: entry_idx = 2'd2;
            S_GUESS_D1: entry_idx = 2'd1;
            S_GUESS_D0: entry_idx = 2'd0;
            default:    entry = 1'b0;
        endcase
    end

    // Only digits to the left of the active one are already committed in this phase.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(entry_idx) && (entry_set ? target[i] : guess[i]) == candidate)
                dup = 1'b1;
        end
    end

    assign sw_valid = entry && (candidate <= 4'd9) && !dup;
    assign match    = (target[3] == guess[3]) && (target[2] == guess[2]) &&
                      (target[1] == guess[1]) && (target[0] == guess[0]);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:        if (confirm) state_nx = S_SET_D3;
            S_SET_D3:      if (confirm && sw_valid) state_nx = S_SET_D2;
            S_SET_D2:      if (confirm && sw_valid) state_nx = S_SET_D1;
            S_SET_D1:      if (confirm && sw_valid) state_nx = S_SET_D0;
            S_SET_D0:      if (confirm && sw_valid) state_nx = S_GUESS_D3;
            S_GUESS_D3:    if (confirm && sw_valid) state_nx = S_GUESS_D2;
            S_GUESS_D2:    if (confirm && sw_valid) state_nx = S_GUESS_D1;
            S_GUESS_D1:    if (confirm && sw_valid) state_nx = S_GUESS_D0;
            S_GUESS_D0:    if (confirm && sw_valid) state_nx = S_SHOW_RESULT;
            S_SHOW_RESULT: if (confirm) state_nx = match ? S_WIN :
                                                   (chances == 3'd0) ? S_LOSE : S_GUESS_D3;
            S_WIN, S_LOSE: if (confirm) state_nx = S_IDLE;
            default:       state_nx = S_IDLE;
        endcase
        if (restart)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            chances   <= 3'(MAX_CHANCES);
            target    <= '{default: 4'd0};
            guess     <= '{default: 4'd0};
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else begin
            state <= state_nx;

            // a state change restarts the blink period visible so the new digit shows at once
            if (state_nx != state) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // every way back into IDLE (restart, game over, illegal encoding) starts a fresh game
            if (restart || (state_nx == S_IDLE && state != S_IDLE)) begin
                chances <= 3'(MAX_CHANCES);
                target  <= '{default: 4'd0};
                guess   <= '{default: 4'd0};
            end else if (confirm && sw_valid) begin
                if (entry_set) begin
                    target[entry_idx] <= candidate;
                    if (state == S_SET_D0)
                        guess <= '{default: 4'd0};
                end else begin
                    guess[entry_idx] <= candidate;
                    if (state == S_GUESS_D0 && chances != 3'd0)
                        chances <= chances - 3'd1;
                end
            end else if (confirm && state == S_SHOW_RESULT && !match && chances != 3'd0) begin
                guess <= '{default: 4'd0};
            end
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;
    import game_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_confirm_n;
    logic       key_restart_n;
    logic [3:0] sw;
    state_t     state;
    logic       blink_on;
    logic [3:0] target [3:0];
    logic [3:0] guess [3:0];
    logic [3:0] candidate;
    logic       sw_valid;
    logic [2:0] chances;

    int checks = 0;
    int errors = 0;

    game_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8), .MAX_CHANCES(5)) dut (
        .clk(clk), .rst_n(rst_n), .key_confirm_n(key_confirm_n), .key_restart_n(key_restart_n),
        .sw(sw), .state(state), .blink_on(blink_on), .target(target), .guess(guess),
        .candidate(candidate), .sw_valid(sw_valid), .chances(chances)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tgt();
        return {target[3], target[2], target[1], target[0]};
    endfunction

    function automatic logic [15:0] gss();
        return {guess[3], guess[2], guess[1], guess[0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_confirm_n = 1'b1;
        key_restart_n = 1'b1;
        sw = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Held 8 cycles: pulse after 2+4 synced cycles, transition one edge later; release clears counter.
    task automatic press_key(input bit rst_key);
        @(negedge clk);
        if (rst_key) key_restart_n = 1'b0; else key_confirm_n = 1'b0;
        repeat (8) @(negedge clk);
        key_restart_n = 1'b1;
        key_confirm_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        @(negedge clk);
        sw = d;
        repeat (2) @(negedge clk);
        press_key(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
        checks++; if (chances !== 3'd5) begin errors++; $display("FAIL reset_chances got %0d exp 5", chances); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL reset_blink got %b exp 1", blink_on); end
        checks++; if (tgt() !== 16'h0000 || gss() !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h/%h exp 0000/0000", tgt(), gss()); end
        checks++; if (sw_valid !== 1'b0) begin errors++; $display("FAIL reset_sw_valid got %b exp 0", sw_valid); end
    endtask

    task automatic test_normal_entry();
        press_key(1'b0);
        checks++; if (state !== S_SET_D3) begin errors++; $display("FAIL idle_to_set got %0d exp %0d", state, S_SET_D3); end
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
        checks++; if (state !== S_GUESS_D3) begin errors++; $display("FAIL set_done_state got %0d exp %0d", state, S_GUESS_D3); end
        checks++; if (tgt() !== 16'h1234) begin errors++; $display("FAIL set_target got %h exp 1234", tgt()); end
        checks++; if (chances !== 3'd5) begin errors++; $display("FAIL set_chances got %0d exp 5", chances); end
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
        checks++; if (state !== S_SHOW_RESULT) begin errors++; $display("FAIL guess_done_state got %0d exp %0d", state, S_SHOW_RESULT); end
        checks++; if (chances !== 3'd4) begin errors++; $display("FAIL guess_chances got %0d exp 4", chances); end
        checks++; if (gss() !== 16'h1234) begin errors++; $display("FAIL guess_digits got %h exp 1234", gss()); end
        press_key(1'b0);
        checks++; if (state !== S_WIN) begin errors++; $display("FAIL win_state got %0d exp %0d", state, S_WIN); end
        press_key(1'b0);
        checks++; if (state !== S_IDLE || chances !== 3'd5) begin errors++; $display("FAIL win_to_idle got %0d/%0d exp %0d/5", state, chances, S_IDLE); end
        checks++; if (tgt() !== 16'h0000) begin errors++; $display("FAIL win_clear_target got %h exp 0000", tgt()); end
    endtask

    task automatic test_validation();
        press_key(1'b0);
        enter_digit(4'd7);
        checks++; if (state !== S_SET_D2) begin errors++; $display("FAIL val_state got %0d exp %0d", state, S_SET_D2); end
        checks++; if (sw_valid !== 1'b0) begin errors++; $display("FAIL val_dup_invalid got %b exp 0", sw_valid); end
        press_key(1'b0);
        checks++; if (state !== S_SET_D2 || tgt() !== 16'h7000) begin errors++; $display("FAIL val_dup_ignored got %0d/%h exp %0d/7000", state, tgt(), S_SET_D2); end
        @(negedge clk); sw = 4'd10; repeat (3) @(negedge clk);
        checks++; if (candidate !== 4'd10) begin errors++; $display("FAIL val_candidate got %0d exp 10", candidate); end
        checks++; if (sw_valid !== 1'b0) begin errors++; $display("FAIL val_ten_invalid got %b exp 0", sw_valid); end
        @(negedge clk); sw = 4'd9; repeat (3) @(negedge clk);
        checks++; if (sw_valid !== 1'b1) begin errors++; $display("FAIL val_nine_valid got %b exp 1", sw_valid); end
        press_key(1'b0);
        checks++; if (state !== S_SET_D1 || tgt() !== 16'h7900) begin errors++; $display("FAIL val_commit got %0d/%h exp %0d/7900", state, tgt(), S_SET_D1); end
        press_key(1'b1);
        checks++; if (state !== S_IDLE || tgt() !== 16'h0000) begin errors++; $display("FAIL val_restart got %0d/%h exp %0d/0000", state, tgt(), S_IDLE); end
    endtask

    task automatic test_lose();
        press_key(1'b0);
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
        for (int i = 0; i < 5; i++) begin
            enter_digit(4'd5); enter_digit(4'd6); enter_digit(4'd7); enter_digit(4'd8);
            checks++; if (state !== S_SHOW_RESULT || chances !== 3'(4 - i)) begin errors++; $display("FAIL lose_round%0d got %0d/%0d exp %0d/%0d", i, state, chances, S_SHOW_RESULT, 4 - i); end
            if (i < 4) begin
                press_key(1'b0);
                checks++; if (state !== S_GUESS_D3 || gss() !== 16'h0000) begin errors++; $display("FAIL lose_retry%0d got %0d/%h exp %0d/0000", i, state, gss(), S_GUESS_D3); end
            end
        end
        press_key(1'b0);
        checks++; if (state !== S_LOSE || chances !== 3'd0) begin errors++; $display("FAIL lose_state got %0d/%0d exp %0d/0", state, chances, S_LOSE); end
        press_key(1'b0);
        checks++; if (state !== S_IDLE || chances !== 3'd5) begin errors++; $display("FAIL lose_to_idle got %0d/%0d exp %0d/5", state, chances, S_IDLE); end
    endtask

    task automatic test_debounce();
        @(negedge clk); key_confirm_n = 1'b0;
        repeat (3) @(negedge clk); key_confirm_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL db_short got %0d exp %0d", state, S_IDLE); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); key_confirm_n = 1'b0;
            @(negedge clk); key_confirm_n = 1'b1;
        end
        repeat (10) @(negedge clk);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL db_glitch got %0d exp %0d", state, S_IDLE); end
        @(negedge clk); key_confirm_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++; if (state !== S_IDLE) begin errors++; $display("FAIL db_early got %0d exp %0d", state, S_IDLE); end
            end
            if (k == 7) begin
                checks++; if (state !== S_SET_D3) begin errors++; $display("FAIL db_latency got %0d exp %0d", state, S_SET_D3); end
            end
        end
        key_confirm_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (state !== S_SET_D3) begin errors++; $display("FAIL db_single got %0d exp %0d", state, S_SET_D3); end
        press_key(1'b1);
    endtask

    task automatic test_blink();
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 18) key_confirm_n = 1'b0;
            if (k == 27) key_confirm_n = 1'b1;
            if (k == 7 || k == 16 || k == 25 || k == 32) begin
                checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_on_c%0d got %b exp 1", k, blink_on); end
            end
            if (k == 8 || k == 15 || k == 24 || k == 33) begin
                checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL blink_off_c%0d got %b exp 0", k, blink_on); end
            end
            if (k == 25) begin
                checks++; if (state !== S_SET_D3) begin errors++; $display("FAIL blink_state_change got %0d exp %0d", state, S_SET_D3); end
            end
        end
        press_key(1'b1);
    endtask

    task automatic test_restart_priority();
        press_key(1'b0);
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
        enter_digit(4'd5); enter_digit(4'd6);
        checks++; if (state !== S_GUESS_D1) begin errors++; $display("FAIL prio_setup got %0d exp %0d", state, S_GUESS_D1); end
        @(negedge clk); sw = 4'd7; repeat (2) @(negedge clk);
        key_confirm_n = 1'b0;
        key_restart_n = 1'b0;
        repeat (8) @(negedge clk);
        key_confirm_n = 1'b1;
        key_restart_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (state !== S_IDLE || chances !== 3'd5) begin errors++; $display("FAIL prio_state got %0d/%0d exp %0d/5", state, chances, S_IDLE); end
        checks++; if (tgt() !== 16'h0000 || gss() !== 16'h0000) begin errors++; $display("FAIL prio_clear got %h/%h exp 0000/0000", tgt(), gss()); end
    endtask

    task automatic test_async_reset();
        press_key(1'b0);
        enter_digit(4'd3);
        checks++; if (state !== S_SET_D2 || tgt() !== 16'h3000) begin errors++; $display("FAIL ar_setup got %0d/%h exp %0d/3000", state, tgt(), S_SET_D2); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (state !== S_IDLE || chances !== 3'd5 || tgt() !== 16'h0000 || blink_on !== 1'b1) begin
            errors++; $display("FAIL ar_immediate got %0d/%0d/%h/%b exp %0d/5/0000/1", state, chances, tgt(), blink_on, S_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        key_confirm_n = 1'b1;
        key_restart_n = 1'b1;
        sw = 4'd0;
        test_reset();
        test_normal_entry();
        test_validation();
        test_lose();
        test_debounce();
        test_blink();
        test_restart_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
